// File: rtl/serializer_nbit_if.sv
// Handshake and serial-stream bundle for serializer_nbit.
// The parallel load side and the serial output side travel together.
interface serializer_nbit_if #(
    parameter int N = 8
);
    logic [N-1:0] d_in;
    logic         load_valid_in;
    logic         load_ready_out;
    logic         en_in;
    logic         q_out;
    logic         q_valid_out;
    logic         last_out;

    modport master (
        output d_in, load_valid_in, en_in,
        input  load_ready_out, q_out, q_valid_out, last_out
    );

    modport slave (
        input  d_in, load_valid_in, en_in,
        output load_ready_out, q_out, q_valid_out, last_out
    );
endinterface

// File: rtl/serializer_nbit.sv
// N-bit parallel-to-serial converter with a one-word hold buffer for gapless frames.
// Optional even-parity trailer bit when SERIALIZER_PARITY_EN is defined.
//
// state    | meaning
// ST_IDLE  | no frame on q_out; an accepted word loads the shift register
// ST_SHIFT | frame in progress; q_out carries a frame bit
module serializer_nbit #(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset_al_in,
    serializer_nbit_if.slave  bus
);

`ifdef SERIALIZER_PARITY_EN
    localparam int L = N + 1;
`else
    localparam int L = N;
`endif
    localparam int            CW       = $clog2(N + 2);
    localparam logic [CW-1:0] LAST_IDX = CW'(L - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  shift_q, shift_d;
    logic [N-1:0]  hold_q, hold_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hold_full_q, hold_full_d;
`ifdef SERIALIZER_PARITY_EN
    logic          parity_q, parity_d;
`endif

    logic          active;
    logic          last;
    logic          accept;
    logic          sr_free;
    logic          out_bit;
    logic [N-1:0]  shift_next;

    assign active  = (state_q == ST_SHIFT);
    assign last    = active && (cnt_q == LAST_IDX);
    assign accept  = bus.load_valid_in && !hold_full_q;
    // The shift register frees up on the edge that retires the last bit,
    // unless the held word is already queued to take its place.
    assign sr_free = !active || (bus.en_in && last && !hold_full_q);

    assign shift_next = MSB_FIRST ? {shift_q[N-2:0], 1'b0}
                                  : {1'b0, shift_q[N-1:1]};

`ifdef SERIALIZER_PARITY_EN
    assign out_bit = (cnt_q == CW'(N)) ? parity_q
                   : (MSB_FIRST ? shift_q[N-1] : shift_q[0]);
`else
    assign out_bit = MSB_FIRST ? shift_q[N-1] : shift_q[0];
`endif

    assign bus.load_ready_out = ~hold_full_q;
    assign bus.q_valid_out    = active;
    assign bus.q_out          = active && out_bit;
    assign bus.last_out       = last;

    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            cnt_q       <= '0;
            hold_full_q <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            hold_full_q <= hold_full_d;
`ifdef SERIALIZER_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        cnt_d       = cnt_q;
        hold_full_d = hold_full_q;
`ifdef SERIALIZER_PARITY_EN
        parity_d    = parity_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SHIFT;
                    shift_d = bus.d_in;
                    cnt_d   = '0;
`ifdef SERIALIZER_PARITY_EN
                    parity_d = ^bus.d_in;
`endif
                end
            end
            ST_SHIFT: begin
                if (bus.en_in) begin
                    if (!last) begin
                        shift_d = shift_next;
                        cnt_d   = cnt_q + 1'b1;
                    end else if (hold_full_q) begin
                        shift_d     = hold_q;
                        cnt_d       = '0;
                        hold_full_d = 1'b0;
`ifdef SERIALIZER_PARITY_EN
                        parity_d    = ^hold_q;
`endif
                    end else if (accept) begin
                        shift_d = bus.d_in;
                        cnt_d   = '0;
`ifdef SERIALIZER_PARITY_EN
                        parity_d = ^bus.d_in;
`endif
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A word that cannot go straight into the shift register waits in hold.
        if (accept && !sr_free) begin
            hold_d      = bus.d_in;
            hold_full_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_serializer_nbit.sv
// Directed bench for serializer_nbit: an MSB-first and an LSB-first instance side by side.
module tb_serializer_nbit;

`ifdef SERIALIZER_PARITY_EN
    localparam int LEN = 9;
`else
    localparam int LEN = 8;
`endif

    logic clk;
    logic reset_al_in;
    int   checks;
    int   errors;

    serializer_nbit_if #(.N(8)) bus0 ();
    serializer_nbit_if #(.N(8)) bus1 ();

    serializer_nbit #(.N(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset_al_in(reset_al_in), .bus(bus0.slave));
    serializer_nbit #(.N(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset_al_in(reset_al_in), .bus(bus1.slave));

    logic [3:0] obs0, obs1;
    assign obs0 = {bus0.load_ready_out, bus0.q_valid_out, bus0.q_out, bus0.last_out};
    assign obs1 = {bus1.load_ready_out, bus1.q_valid_out, bus1.q_out, bus1.last_out};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         sel;
        logic [7:0] word;
        logic [7:0] seq;   // expected serial order, first bit in seq[7]
        logic       par;
        string      name;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [3:0] obs(int sel);
        return (sel == 0) ? obs0 : obs1;
    endfunction

    function automatic logic exp_bit(logic [7:0] seq, logic par, int i);
        return (i < 8) ? seq[7-i] : par;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int sel, logic v, logic [7:0] d, logic e);
        if (sel == 0) begin
            bus0.load_valid_in = v; bus0.d_in = d; bus0.en_in = e;
        end else begin
            bus1.load_valid_in = v; bus1.d_in = d; bus1.en_in = e;
        end
    endtask

    task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: {rdy,vld,q,last} got %b expected %b", name, act, exp);
        end
    endtask

    task automatic send_and_check(int sel, logic [7:0] word, logic [7:0] seq,
                                  logic par, string name);
        drive(sel, 1'b1, word, 1'b1);
        chk({name, " ready"}, obs(sel), 4'b1000);
        tick();
        drive(sel, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < LEN; i++) begin
            chk($sformatf("%s bit%0d", name, i), obs(sel),
                {1'b1, 1'b1, exp_bit(seq, par, i), (i == LEN - 1)});
            tick();
        end
        chk({name, " end"}, obs(sel), 4'b1000);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        vecs[0] = '{0, 8'hA5, 8'hA5, 1'b0, "a5_msb"};
        vecs[1] = '{0, 8'h3C, 8'h3C, 1'b0, "3c_msb"};
        vecs[2] = '{0, 8'h80, 8'h80, 1'b1, "80_msb"};
        vecs[3] = '{0, 8'hFF, 8'hFF, 1'b0, "ff_msb"};
        vecs[4] = '{0, 8'h00, 8'h00, 1'b0, "00_msb"};
        vecs[5] = '{0, 8'h01, 8'h01, 1'b1, "01_msb"};
        vecs[6] = '{1, 8'h01, 8'h80, 1'b1, "01_lsb"};
        vecs[7] = '{1, 8'hA5, 8'hA5, 1'b0, "a5_lsb"};
        vecs[8] = '{1, 8'h0F, 8'hF0, 1'b0, "0f_lsb"};
        vecs[9] = '{1, 8'h12, 8'h48, 1'b0, "12_lsb"};

        drive(0, 1'b0, 8'h00, 1'b1);
        drive(1, 1'b0, 8'h00, 1'b1);
        reset_al_in = 1'b0;
        #12;
        chk("reset msb", obs0, 4'b1000);
        chk("reset lsb", obs1, 4'b1000);
        @(negedge clk);
        reset_al_in = 1'b1;

        // first frame accepted on the first edge after release
        for (int v = 0; v < 10; v++)
            send_and_check(vecs[v].sel, vecs[v].word, vecs[v].seq, vecs[v].par, vecs[v].name);

        // back-to-back frames: 0xA5 then 0x3C held, no gap
        drive(0, 1'b1, 8'hA5, 1'b1);
        tick();
        drive(0, 1'b1, 8'h3C, 1'b1);
        for (int i = 0; i < 2 * LEN; i++) begin
            logic [7:0] s;
            logic       rdy;
            s   = (i < LEN) ? 8'hA5 : 8'h3C;
            rdy = (i == 0) || (i >= LEN);
            chk($sformatf("b2b bit%0d", i), obs0,
                {rdy, 1'b1, exp_bit(s, 1'b0, i % LEN), ((i % LEN) == LEN - 1)});
            tick();
            if (i == 0) drive(0, 1'b0, 8'h00, 1'b1);
        end
        chk("b2b end", obs0, 4'b1000);

        // en_in low for three cycles while bit 2 of 0xF0 is on q_out
        drive(0, 1'b1, 8'hF0, 1'b1);
        tick();
        for (int c = 0; c < LEN + 3; c++) begin
            int idx;
            idx = (c <= 2) ? c : ((c <= 5) ? 2 : c - 3);
            drive(0, 1'b0, 8'h00, !(c >= 2 && c <= 4));
            chk($sformatf("freeze cyc%0d", c), obs0,
                {1'b1, 1'b1, exp_bit(8'hF0, 1'b0, idx), (idx == LEN - 1)});
            tick();
        end
        chk("freeze end", obs0, 4'b1000);
        drive(0, 1'b0, 8'h00, 1'b1);

        // reset mid-cycle at bit 4 with 0x3C in hold
        drive(0, 1'b1, 8'hA5, 1'b1);
        tick();
        drive(0, 1'b1, 8'h3C, 1'b1);
        tick();
        drive(0, 1'b0, 8'h00, 1'b1);
        repeat (3) tick();
        chk("pre-reset bit4", obs0, 4'b0100);
        #2;
        reset_al_in = 1'b0;
        #1;
        chk("async reset msb", obs0, 4'b1000);
        chk("async reset lsb", obs1, 4'b1000);
        @(negedge clk);
        reset_al_in = 1'b1;
        for (int i = 0; i < LEN + 2; i++) begin
            tick();
            chk($sformatf("post-reset idle%0d", i), obs0, 4'b1000);
        end

        // second reset, then accept on the very first edge after release
        @(negedge clk);
        reset_al_in = 1'b0;
        @(negedge clk);
        reset_al_in = 1'b1;
        send_and_check(0, 8'h5A, 8'h5A, 1'b0, "first_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
